// File: rtl/sample_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sample_tick_scheduler
// Description : Sample-rate tick generator for phoneme playback, with
//               per-segment tick counting and a one-deep shadow config slot.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_tick_scheduler #(
    parameter int CNT_W   = 32,
    parameter int LEN_W   = 24,
    parameter int MIN_DIV = 2
) (
    input  logic             clk_input,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_divisor,
    input  logic [LEN_W-1:0] cfg_length,
    input  logic             abort,
    output logic             tick,
    output logic [LEN_W-1:0] sample_index,
    output logic             busy,
    output logic             seg_done
);

    localparam logic [CNT_W-1:0] c_MIN_DIV = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] c_ONE_CNT = CNT_W'(1);
    localparam logic [LEN_W-1:0] c_ONE_LEN = LEN_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state,        w_state_nxt;
    logic [CNT_W-1:0]   r_counter,      w_counter_nxt;
    logic [LEN_W-1:0]   r_sample_index, w_sample_index_nxt;
    logic [CNT_W-1:0]   r_active_div,   w_active_div_nxt;
    logic [LEN_W-1:0]   r_active_len,   w_active_len_nxt;
    logic [CNT_W-1:0]   r_shadow_div,   w_shadow_div_nxt;
    logic [LEN_W-1:0]   r_shadow_len,   w_shadow_len_nxt;
    logic               r_shadow_full,  w_shadow_full_nxt;

    logic [CNT_W-1:0]   w_eff_div;
    logic [LEN_W-1:0]   w_eff_len;
    logic               w_accept;
    logic               w_last;

    assign w_eff_div    = (cfg_divisor < c_MIN_DIV) ? c_MIN_DIV : cfg_divisor;
    assign w_eff_len    = (cfg_length == '0) ? c_ONE_LEN : cfg_length;

    assign cfg_ready    = !reset && !r_shadow_full && !abort;
    assign w_accept     = cfg_valid && cfg_ready;

    // Tick is decoded from registered state; abort and reset mask it in-cycle.
    assign tick         = (r_state == ST_RUN) && (r_counter == r_active_div - c_ONE_CNT)
                          && !abort && !reset;
    assign w_last       = (r_sample_index == r_active_len - c_ONE_LEN);
    assign seg_done     = tick && w_last;
    assign busy         = (r_state == ST_RUN) && !reset;
    assign sample_index = r_sample_index;

    always_comb begin
        w_state_nxt        = r_state;
        w_counter_nxt      = r_counter;
        w_sample_index_nxt = r_sample_index;
        w_active_div_nxt   = r_active_div;
        w_active_len_nxt   = r_active_len;
        w_shadow_div_nxt   = r_shadow_div;
        w_shadow_len_nxt   = r_shadow_len;
        w_shadow_full_nxt  = r_shadow_full;

        if (w_accept) begin
            w_shadow_div_nxt  = w_eff_div;
            w_shadow_len_nxt  = w_eff_len;
            w_shadow_full_nxt = 1'b1;
        end

        if (abort) begin
            w_state_nxt        = ST_IDLE;
            w_counter_nxt      = '0;
            w_sample_index_nxt = '0;
            w_shadow_full_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_shadow_full) begin
                        w_active_div_nxt   = r_shadow_div;
                        w_active_len_nxt   = r_shadow_len;
                        w_shadow_full_nxt  = 1'b0;
                        w_counter_nxt      = '0;
                        w_sample_index_nxt = '0;
                        w_state_nxt        = ST_RUN;
                    end
                end
                ST_RUN: begin
                    w_counter_nxt = r_counter + c_ONE_CNT;
                    if (tick) begin
                        w_counter_nxt = '0;
                        if (w_last) begin
                            w_sample_index_nxt = '0;
                            if (r_shadow_full) begin
                                w_active_div_nxt  = r_shadow_div;
                                w_active_len_nxt  = r_shadow_len;
                                w_shadow_full_nxt = 1'b0;
                            end else if (w_accept) begin
                                // Bypass the shadow: a config offered on the last
                                // tick becomes the active segment directly.
                                w_active_div_nxt  = w_eff_div;
                                w_active_len_nxt  = w_eff_len;
                                w_shadow_full_nxt = 1'b0;
                            end else begin
                                w_state_nxt = ST_IDLE;
                            end
                        end else begin
                            w_sample_index_nxt = r_sample_index + c_ONE_LEN;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_input) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_counter      <= '0;
            r_sample_index <= '0;
            r_active_div   <= '0;
            r_active_len   <= '0;
            r_shadow_div   <= '0;
            r_shadow_len   <= '0;
            r_shadow_full  <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_counter      <= w_counter_nxt;
            r_sample_index <= w_sample_index_nxt;
            r_active_div   <= w_active_div_nxt;
            r_active_len   <= w_active_len_nxt;
            r_shadow_div   <= w_shadow_div_nxt;
            r_shadow_len   <= w_shadow_len_nxt;
            r_shadow_full  <= w_shadow_full_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sample_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_tick_scheduler
// Description : Self-checking bench: directed scenarios plus random traffic,
//               compared each cycle against a queue-based segment model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_tick_scheduler;

    logic        clk_input = 1'b0;
    logic        reset     = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_divisor = '0;
    logic [23:0] cfg_length  = '0;
    logic        abort = 1'b0;
    logic        tick;
    logic [23:0] sample_index;
    logic        busy;
    logic        seg_done;

    sample_tick_scheduler #(.CNT_W(32), .LEN_W(24), .MIN_DIV(2)) dut (
        .clk_input    (clk_input),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_divisor  (cfg_divisor),
        .cfg_length   (cfg_length),
        .abort        (abort),
        .tick         (tick),
        .sample_index (sample_index),
        .busy         (busy),
        .seg_done     (seg_done)
    );

    always #5 clk_input = ~clk_input;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: current segment as "cycles until next tick" plus a
    // pending-config queue of depth at most one.
    logic        m_busy = 1'b0;
    int unsigned m_div  = 0;
    int unsigned m_len  = 0;
    int unsigned m_wait = 0;
    int unsigned m_idx  = 0;
    int unsigned q_div[$];
    int unsigned q_len[$];
    logic        last_acc = 1'b0;

    // Tick timing log, in clock edges from the edge that raised busy.
    int          cyc = 0;
    int          rise_cyc = 0;
    logic        prev_busy = 1'b0;
    int          deltas[$];
    int          done_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic start_next();
        m_div  = q_div.pop_front();
        m_len  = q_len.pop_front();
        m_wait = m_div;
        m_idx  = 0;
        m_busy = 1'b1;
    endtask

    task automatic run_cycle(input logic v, input int unsigned d, input int unsigned l,
                             input logic a, input logic r);
        logic e_ready, e_tick, e_done;
        cfg_valid   = v;
        cfg_divisor = d;
        cfg_length  = l[23:0];
        abort       = a;
        reset       = r;
        @(negedge clk_input);
        e_ready = !r && (q_div.size() == 0) && !a;
        e_tick  = !r && !a && m_busy && (m_wait == 1);
        e_done  = e_tick && (m_idx == m_len - 1);
        check_eq("cfg_ready", {63'd0, cfg_ready}, {63'd0, e_ready});
        check_eq("tick",      {63'd0, tick},      {63'd0, e_tick});
        check_eq("seg_done",  {63'd0, seg_done},  {63'd0, e_done});
        check_eq("busy",      {63'd0, busy},      {63'd0, m_busy && !r});
        if (!r)
            check_eq("sample_index", {40'd0, sample_index}, 64'(m_idx));
        cyc++;
        if (busy && !prev_busy) rise_cyc = cyc;
        prev_busy = busy;
        if (tick) deltas.push_back(cyc - rise_cyc + 1);
        if (seg_done) done_cnt++;

        @(posedge clk_input);
        last_acc = v && e_ready;
        if (r || a) begin
            m_busy = 1'b0;
            m_idx  = 0;
            q_div.delete();
            q_len.delete();
        end else begin
            if (last_acc) begin
                q_div.push_back(d < 2 ? 2 : d);
                q_len.push_back(l == 0 ? 1 : l);
            end
            if (m_busy) begin
                if (e_tick) begin
                    if (e_done) begin
                        if (q_div.size() > 0) start_next();
                        else begin
                            m_busy = 1'b0;
                            m_idx  = 0;
                        end
                    end else begin
                        m_idx++;
                        m_wait = m_div;
                    end
                end else begin
                    m_wait--;
                end
            end else if (q_div.size() > 0 && !last_acc) begin
                start_next();
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic send(input int unsigned d, input int unsigned l);
        for (int i = 0; i < 100; i++) begin
            run_cycle(1'b1, d, l, 1'b0, 1'b0);
            if (last_acc) return;
        end
        check_eq("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_deltas(input string name, input int exp[$]);
        check_eq({name, "_count"}, 64'(deltas.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            check_eq($sformatf("%s_t%0d", name, i),
                     64'(i < deltas.size() ? deltas[i] : -1), 64'(exp[i]));
        deltas.delete();
        done_cnt = 0;
    endtask

    initial begin
        int k;
        run_cycle(1'b0, 0, 0, 1'b0, 1'b1);
        run_cycle(1'b0, 0, 0, 1'b0, 1'b1);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_index", {40'd0, sample_index}, 64'd0);
        idle(2);
        deltas.delete();
        done_cnt = 0;

        // Basic segment
        send(5, 3);
        idle(20);
        check_eq("basic_done_cnt", 64'(done_cnt), 64'd1);
        check_deltas("basic", '{5, 10, 15});

        // Chained segments with no gap
        send(4, 2);
        send(6, 2);
        idle(30);
        check_eq("chain_done_cnt", 64'(done_cnt), 64'd2);
        check_deltas("chain", '{4, 8, 14, 20});

        // Clamping of divisor and length
        send(0, 0);
        idle(10);
        check_eq("clamp_done_cnt", 64'(done_cnt), 64'd1);
        check_deltas("clamp", '{2});

        // Abort mid-run with a pending shadow
        send(10, 8);
        send(5, 5);
        k = 0;
        while (deltas.size() < 3 && k < 200) begin
            idle(1);
            k++;
        end
        check_eq("abort_wait_timeout", 64'(k < 200), 64'd1);
        run_cycle(1'b0, 0, 0, 1'b1, 1'b0);
        idle(1);
        check_eq("abort_ready", {63'd0, cfg_ready}, 64'd1);
        check_eq("abort_busy", {63'd0, busy}, 64'd0);
        idle(60);
        check_deltas("abort", '{10, 20, 30});

        // Reset mid-operation with a pending shadow
        send(7, 4);
        send(3, 2);
        idle(10);
        run_cycle(1'b0, 0, 0, 1'b0, 1'b1);
        deltas.delete();
        send(3, 1);
        idle(10);
        check_deltas("reset_mid", '{3});

        // Config offered exactly on the last tick
        send(4, 2);
        k = 0;
        while (!(m_busy && m_wait == 1 && m_idx == m_len - 1) && k < 50) begin
            idle(1);
            k++;
        end
        check_eq("lasttick_wait_timeout", 64'(k < 50), 64'd1);
        run_cycle(1'b1, 5, 1, 1'b0, 1'b0);
        check_eq("lasttick_accept", {63'd0, last_acc}, 64'd1);
        idle(15);
        check_deltas("lasttick", '{4, 8, 13});

        // Random traffic
        for (int i = 0; i < 3000; i++)
            run_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 4),
                      $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
